wb_commit: RTL and testbench

Writeback/commit stage for the LoongArch pipeline, and the initiator on the CSR file's interface. It latches one instruction per cycle from MEM and retires it. For CSR instructions it drives the CSR number, write enable, data and mask. For exceptions and `ertn` it drives the exception/return strobes with code, subcode and PC, flushes the pipeline, and holds a registered redirect to IF until IF accepts it.

---
 rtl/wb_csr_if.sv | 27 ++
 rtl/wb_commit.sv | 147 ++++++++++++++
 tb/tb_wb_commit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_csr_if.sv
// Bus between the writeback/commit stage (initiator) and the CSR file:
// CSR read/write access plus exception/ertn commit strobes and the redirect target.
interface wb_csr_if;
  logic [13:0] csr_num;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic        exc_signal;
  logic        ertn_signal;
  logic [5:0]  exc_ecode;
  logic [8:0]  exc_esubcode;
  logic [31:0] exc_pc;
  logic [31:0] csr_redirect_pc;

  modport master (
    output csr_num, csr_we, csr_wdata, csr_wmask,
    output exc_signal, ertn_signal, exc_ecode, exc_esubcode, exc_pc,
    input  csr_rdata, csr_redirect_pc
  );

  modport slave (
    input  csr_num, csr_we, csr_wdata, csr_wmask,
    input  exc_signal, ertn_signal, exc_ecode, exc_esubcode, exc_pc,
    output csr_rdata, csr_redirect_pc
  );
endinterface

// File: rtl/wb_commit.sv
// LoongArch32 writeback/commit stage: retires one instruction per cycle, drives CSR
// accesses and exception/ertn commits, and holds a registered redirect to IF.
module wb_commit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_rd,
  input  logic [31:0] ms_result,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rj_value,
  input  logic [31:0] ms_rkd_value,
  input  logic        ms_ertn,
  input  logic        ms_exc,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  wb_csr_if.master    csr,
  output logic        ws_flush,
  output logic        if_redirect_valid,
  output logic [31:0] if_redirect_pc,
  input  logic        if_redirect_ready,
  output logic        ws_csr_busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t      r_state;
  logic        r_ws_valid;
  logic        r_redir_valid;
  logic [31:0] r_redir_pc;

  logic [31:0] r_ws_pc;
  logic        r_ws_gr_we;
  logic [4:0]  r_ws_rd;
  logic [31:0] r_ws_result;
  logic [1:0]  r_ws_csr_op;
  logic [13:0] r_ws_csr_num;
  logic [31:0] r_ws_rj_value;
  logic [31:0] r_ws_rkd_value;
  logic        r_ws_ertn;
  logic        r_ws_exc;
  logic [5:0]  r_ws_ecode;
  logic [8:0]  r_ws_esubcode;

  logic w_exc;
  logic w_ertn;
  logic w_csr;
  logic w_csr_we;
  logic w_flush;

  // WB never stalls; in WAIT accepted instructions are simply dropped.
  assign ws_allowin = 1'b1;

  assign w_exc    = r_ws_valid & r_ws_exc;
  assign w_ertn   = r_ws_valid & r_ws_ertn & ~r_ws_exc;
  assign w_csr    = r_ws_valid & ~r_ws_exc & ~r_ws_ertn & (r_ws_csr_op != 2'b00);
  assign w_csr_we = w_csr & r_ws_csr_op[1];
  assign w_flush  = w_exc | w_ertn;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_RUN;
      r_ws_valid    <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'h0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_flush) begin
            r_state       <= S_WAIT;
            r_ws_valid    <= 1'b0;
            r_redir_valid <= 1'b1;
            r_redir_pc    <= csr.csr_redirect_pc;
          end else begin
            r_ws_valid    <= ms_to_ws_valid & ws_allowin;
          end
        end
        S_WAIT: begin
          r_ws_valid <= 1'b0;
          if (r_redir_valid && if_redirect_ready) begin
            r_state       <= S_RUN;
            r_redir_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_ws_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage data fields carry no reset; every consumer is qualified by r_ws_valid.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      r_ws_pc        <= ms_pc;
      r_ws_gr_we     <= ms_gr_we;
      r_ws_rd        <= ms_rd;
      r_ws_result    <= ms_result;
      r_ws_csr_op    <= ms_csr_op;
      r_ws_csr_num   <= ms_csr_num;
      r_ws_rj_value  <= ms_rj_value;
      r_ws_rkd_value <= ms_rkd_value;
      r_ws_ertn      <= ms_ertn;
      r_ws_exc       <= ms_exc;
      r_ws_ecode     <= ms_ecode;
      r_ws_esubcode  <= ms_esubcode;
    end
  end

  assign csr.csr_num      = w_csr ? r_ws_csr_num : 14'h0;
  assign csr.csr_we       = w_csr_we;
  assign csr.csr_wdata    = w_csr_we ? r_ws_rkd_value : 32'h0;
  assign csr.csr_wmask    = !w_csr_we ? 32'h0 :
                            (r_ws_csr_op == 2'b10) ? 32'hFFFF_FFFF : r_ws_rj_value;
  assign csr.exc_signal   = w_exc;
  assign csr.ertn_signal  = w_ertn;
  assign csr.exc_ecode    = w_exc ? r_ws_ecode : 6'h0;
  assign csr.exc_esubcode = w_exc ? r_ws_esubcode : 9'h0;
  assign csr.exc_pc       = w_exc ? r_ws_pc : 32'h0;

  assign ws_flush          = w_flush;
  assign ws_csr_busy       = w_csr_we | w_flush;
  assign if_redirect_valid = r_redir_valid;
  assign if_redirect_pc    = r_redir_pc;

  // CSR instructions return the old CSR value read in the same cycle as the write.
  assign rf_we    = r_ws_valid & r_ws_gr_we & ~w_flush & (r_ws_rd != 5'd0);
  assign rf_waddr = r_ws_valid ? r_ws_rd : 5'd0;
  assign rf_wdata = !r_ws_valid ? 32'h0 : (w_csr ? csr.csr_rdata : r_ws_result);

  assign debug_wb_pc       = r_ws_valid ? r_ws_pc : 32'h0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: CSR ops, normal retire, exception/ertn redirect, WAIT discard, reset in WAIT.
module tb_wb_commit;
  logic        clk;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_rd;
  logic [31:0] ms_result;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj_value;
  logic [31:0] ms_rkd_value;
  logic        ms_ertn;
  logic        ms_exc;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ws_flush;
  logic        if_redirect_valid;
  logic [31:0] if_redirect_pc;
  logic        if_redirect_ready;
  logic        ws_csr_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  wb_csr_if csr_bus();

  wb_commit dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_rd             (ms_rd),
    .ms_result         (ms_result),
    .ms_csr_op         (ms_csr_op),
    .ms_csr_num        (ms_csr_num),
    .ms_rj_value       (ms_rj_value),
    .ms_rkd_value      (ms_rkd_value),
    .ms_ertn           (ms_ertn),
    .ms_exc            (ms_exc),
    .ms_ecode          (ms_ecode),
    .ms_esubcode       (ms_esubcode),
    .csr               (csr_bus),
    .ws_flush          (ws_flush),
    .if_redirect_valid (if_redirect_valid),
    .if_redirect_pc    (if_redirect_pc),
    .if_redirect_ready (if_redirect_ready),
    .ws_csr_busy       (ws_csr_busy),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic gr_we, input logic [4:0] rd,
                       input logic [31:0] result, input logic [1:0] op, input logic [13:0] num,
                       input logic [31:0] rj, input logic [31:0] rkd, input logic ertn,
                       input logic exc, input logic [5:0] ecode, input logic [8:0] esub);
    ms_pc = pc; ms_gr_we = gr_we; ms_rd = rd; ms_result = result;
    ms_csr_op = op; ms_csr_num = num; ms_rj_value = rj; ms_rkd_value = rkd;
    ms_ertn = ertn; ms_exc = exc; ms_ecode = ecode; ms_esubcode = esub;
    ms_to_ws_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    ms_to_ws_valid = 1'b0;
    if_redirect_ready = 1'b0;
    csr_bus.csr_rdata = 32'h0;
    csr_bus.csr_redirect_pc = 32'h0;
    drive(32'h0, 1'b0, 5'd0, 32'h0, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    ms_to_ws_valid = 1'b0;
    step(); step();

    // Reset state
    @(negedge clk);
    check("rst_allowin",   {31'h0, ws_allowin}, 32'h1);
    check("rst_redir_vld", {31'h0, if_redirect_valid}, 32'h0);
    check("rst_redir_pc",  if_redirect_pc, 32'h0);
    check("rst_rf_we",     {31'h0, rf_we}, 32'h0);
    check("rst_exc",       {31'h0, csr_bus.exc_signal}, 32'h0);
    check("rst_csr_we",    {31'h0, csr_bus.csr_we}, 32'h0);
    check("rst_csr_num",   {18'h0, csr_bus.csr_num}, 32'h0);
    check("rst_dbg_pc",    debug_wb_pc, 32'h0);
    resetn = 1'b1;
    step();

    // csrwr
    csr_bus.csr_rdata = 32'h11;
    drive(32'h1C00_0000, 1'b1, 5'd4, 32'h0, 2'b10, 14'h30, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'h0, 9'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("csrwr_we",    {31'h0, csr_bus.csr_we}, 32'h1);
    check("csrwr_num",   {18'h0, csr_bus.csr_num}, 32'h30);
    check("csrwr_mask",  csr_bus.csr_wmask, 32'hFFFF_FFFF);
    check("csrwr_wdata", csr_bus.csr_wdata, 32'hDEAD_BEEF);
    check("csrwr_rf_we", {31'h0, rf_we}, 32'h1);
    check("csrwr_waddr", {27'h0, rf_waddr}, 32'h4);
    check("csrwr_rf_wd", rf_wdata, 32'h11);
    check("csrwr_busy",  {31'h0, ws_csr_busy}, 32'h1);
    check("csrwr_dbgwe", {28'h0, debug_wb_rf_we}, 32'hF);
    check("csrwr_dbgpc", debug_wb_pc, 32'h1C00_0000);
    @(negedge clk);
    check("csrwr_once_we", {31'h0, csr_bus.csr_we}, 32'h0);
    check("csrwr_once_rf", {31'h0, rf_we}, 32'h0);
    step();

    // csrxchg
    csr_bus.csr_rdata = 32'h0000_AA55;
    drive(32'h1C00_0004, 1'b1, 5'd5, 32'h0, 2'b11, 14'h6, 32'h0000_FF00, 32'h1234_5678, 1'b0, 1'b0, 6'h0, 9'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("xchg_we",    {31'h0, csr_bus.csr_we}, 32'h1);
    check("xchg_mask",  csr_bus.csr_wmask, 32'h0000_FF00);
    check("xchg_wdata", csr_bus.csr_wdata, 32'h1234_5678);
    check("xchg_rf_wd", rf_wdata, 32'h0000_AA55);
    step();

    // csrrd: no CSR write, old value to rd
    csr_bus.csr_rdata = 32'h0000_0777;
    drive(32'h1C00_0008, 1'b1, 5'd6, 32'h5, 2'b01, 14'hC, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("csrrd_we",   {31'h0, csr_bus.csr_we}, 32'h0);
    check("csrrd_num",  {18'h0, csr_bus.csr_num}, 32'hC);
    check("csrrd_rfwd", rf_wdata, 32'h0000_0777);
    check("csrrd_busy", {31'h0, ws_csr_busy}, 32'h0);
    step();

    // normal retire, then rd=0 suppressed
    drive(32'h1C00_000C, 1'b1, 5'd7, 32'hCAFE_0001, 2'b00, 14'h3F, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    step();
    drive(32'h1C00_0010, 1'b1, 5'd0, 32'hCAFE_0002, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    @(negedge clk);
    check("norm_rf_we",  {31'h0, rf_we}, 32'h1);
    check("norm_waddr",  {27'h0, debug_wb_rf_wnum}, 32'h7);
    check("norm_wdata",  debug_wb_rf_wdata, 32'hCAFE_0001);
    check("norm_csrnum", {18'h0, csr_bus.csr_num}, 32'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("r0_rf_we", {31'h0, rf_we}, 32'h0);
    step();

    // Exception; a MEM instruction offered in T is discarded
    csr_bus.csr_redirect_pc = 32'h1C00_8000;
    drive(32'h1C00_0100, 1'b1, 5'd8, 32'h9, 2'b10, 14'h1, 32'h0, 32'h5, 1'b0, 1'b1, 6'h0B, 9'h0);
    step();
    drive(32'h1C00_0104, 1'b1, 5'd9, 32'h99, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    @(negedge clk);
    check("exc_sig",    {31'h0, csr_bus.exc_signal}, 32'h1);
    check("exc_ertn",   {31'h0, csr_bus.ertn_signal}, 32'h0);
    check("exc_flush",  {31'h0, ws_flush}, 32'h1);
    check("exc_rf_we",  {31'h0, rf_we}, 32'h0);
    check("exc_csr_we", {31'h0, csr_bus.csr_we}, 32'h0);
    check("exc_ecode",  {26'h0, csr_bus.exc_ecode}, 32'h0B);
    check("exc_pc",     csr_bus.exc_pc, 32'h1C00_0100);
    check("exc_busy",   {31'h0, ws_csr_busy}, 32'h1);
    check("exc_rv_T",   {31'h0, if_redirect_valid}, 32'h0);
    step();
    ms_to_ws_valid = 1'b0;
    csr_bus.csr_redirect_pc = 32'h0000_0BAD;
    @(negedge clk);
    check("exc_T1_rv",    {31'h0, if_redirect_valid}, 32'h1);
    check("exc_T1_pc",    if_redirect_pc, 32'h1C00_8000);
    check("exc_T1_sig",   {31'h0, csr_bus.exc_signal}, 32'h0);
    check("exc_T1_flush", {31'h0, ws_flush}, 32'h0);
    check("exc_T1_drop",  {31'h0, rf_we}, 32'h0);
    step();
    @(negedge clk);
    check("exc_T2_rv", {31'h0, if_redirect_valid}, 32'h1);
    check("exc_T2_pc", if_redirect_pc, 32'h1C00_8000);
    step();
    if_redirect_ready = 1'b1;
    @(negedge clk);
    check("exc_T3_rv", {31'h0, if_redirect_valid}, 32'h1);
    check("exc_T3_pc", if_redirect_pc, 32'h1C00_8000);
    step();
    if_redirect_ready = 1'b0;
    drive(32'h1C00_8000, 1'b1, 5'd10, 32'hA5A5_0000, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    @(negedge clk);
    check("exc_T4_rv", {31'h0, if_redirect_valid}, 32'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("exc_resume_we", {31'h0, rf_we}, 32'h1);
    check("exc_resume_wd", rf_wdata, 32'hA5A5_0000);
    step();

    // Plain ertn, ack in T+1
    csr_bus.csr_redirect_pc = 32'h1C00_0200;
    drive(32'h1C00_0300, 1'b1, 5'd3, 32'h1, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 1'b0, 6'h3, 9'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("ertn_sig",   {31'h0, csr_bus.ertn_signal}, 32'h1);
    check("ertn_exc",   {31'h0, csr_bus.exc_signal}, 32'h0);
    check("ertn_ecode", {26'h0, csr_bus.exc_ecode}, 32'h0);
    check("ertn_flush", {31'h0, ws_flush}, 32'h1);
    check("ertn_rf_we", {31'h0, rf_we}, 32'h0);
    step();
    if_redirect_ready = 1'b1;
    @(negedge clk);
    check("ertn_T1_rv", {31'h0, if_redirect_valid}, 32'h1);
    check("ertn_T1_pc", if_redirect_pc, 32'h1C00_0200);
    step();
    if_redirect_ready = 1'b0;
    @(negedge clk);
    check("ertn_T2_rv", {31'h0, if_redirect_valid}, 32'h0);
    step();

    // ertn with exception: only exc fires; then 3 back-to-back MEM instructions in WAIT
    csr_bus.csr_redirect_pc = 32'h1C00_9000;
    drive(32'h1C00_0400, 1'b1, 5'd2, 32'h2, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h08, 9'h1);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("ee_exc",  {31'h0, csr_bus.exc_signal}, 32'h1);
    check("ee_ertn", {31'h0, csr_bus.ertn_signal}, 32'h0);
    check("ee_sub",  {23'h0, csr_bus.exc_esubcode}, 32'h1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(32'h1C00_0500 + 32'(i * 4), 1'b1, 5'(11 + i), 32'(i + 1), 2'b00, 14'h0,
            32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
      step();
      @(negedge clk);
      check("wait_rf_we",  {31'h0, rf_we}, 32'h0);
      check("wait_dbg_we", {28'h0, debug_wb_rf_we}, 32'h0);
    end
    ms_to_ws_valid = 1'b0;

    // Reset during WAIT: redirect drops next cycle, then normal retire
    csr_bus.csr_redirect_pc = 32'h1C00_A000;
    if_redirect_ready = 1'b1;
    step();
    if_redirect_ready = 1'b0;
    step();
    drive(32'h1C00_0600, 1'b1, 5'd1, 32'h1, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6'h4, 9'h0);
    step();
    ms_to_ws_valid = 1'b0;
    step();
    @(negedge clk);
    check("rw_T1_rv", {31'h0, if_redirect_valid}, 32'h1);
    step();
    resetn = 1'b0;
    @(negedge clk);
    check("rw_T2_rv", {31'h0, if_redirect_valid}, 32'h1);
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("rw_rv_drop", {31'h0, if_redirect_valid}, 32'h0);
    check("rw_allowin", {31'h0, ws_allowin}, 32'h1);
    drive(32'h1C00_0700, 1'b1, 5'd12, 32'h7777_0000, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("rw_retire_we", {31'h0, rf_we}, 32'h1);
    check("rw_retire_wd", rf_wdata, 32'h7777_0000);
    check("rw_retire_pc", debug_wb_pc, 32'h1C00_0700);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
